bigsub: RTL and testbench
=========================

// Module: bigsub
// PURPOSE
//  Pipelined 64-bit unsigned subtractor, o_r = i_a - i_b, with a sync strobe
//  carried alongside the data. It is the inverse of the pipelined 64-bit adder
//  used in the RTC/PPS timing path, and computes time differences and
//  phase errors between 64-bit counters. The borrow ripples one chunk per
//  clock so that timing closes at full fabric rate.
// PARAMETERS
//  NCLOCKS  1  pipeline depth; legal values 1, 2, 4; 64/NCLOCKS bits per chunk
// PORTS
//  i_clk    in   1   system clock
//  i_reset  in   1   asynchronous reset, active high
//  i_sync   in   1   strobe: i_a/i_b valid this cycle
//  i_a      in   64  minuend, unsigned
//  i_b      in   64  subtrahend, unsigned
//  o_r      out  64  difference, modulo 2^64
//  o_borrow out  1   1 when i_a < i_b (unsigned), aligned with o_r
//  o_sync   out  1   strobe: o_r/o_borrow valid this cycle
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is asynchronous and active-high.
//  - While i_reset is high, every pipeline register (data, borrow, sync) is
//    0. That gives o_r=0, o_borrow=0 and o_sync=0.
//  - Latency: exactly NCLOCKS cycles from i_sync to o_sync.
//    o_r and o_borrow belong to the operands presented on that i_sync.
//  - Throughput: one operation per clock. There is no stall or backpressure.
//    i_sync may be high on every cycle.
//  - Registers load every clock whether or not i_sync is high. Outputs are
//    defined only when o_sync=1; o_sync is the only qualifier.
//  - Chunk W = 64/NCLOCKS.
//    - Stage 1 computes chunk 0 as {b0, r0} = {1'b0, a0} - {1'b0, b0}.
//    - Stage k (k = 2..NCLOCKS) computes chunk k-1 as a - b - borrow(k-2).
//      The operands for that chunk are delayed k-1 cycles to line up.
//    - Finished low chunks are delayed so that all chunks leave together.
//    - o_borrow is the borrow out of the top chunk.
//  - NCLOCKS=1: a single registered 65-bit subtract.
//  - Wrap-around: the result is modulo 2^64 with no sign handling.
//    0 - 1 gives FFFF_FFFF_FFFF_FFFF with borrow 1.
//  - Equal operands give 0 with borrow 0.
//  - i_sync pulses in consecutive cycles give outputs in consecutive cycles,
//    in order and with no mixing between them.
//  - Reset mid-operation:
//    - All in-flight results and sync bits are discarded.
//    - o_sync stays 0 until an i_sync presented after reset deasserts has
//      traversed the full NCLOCKS stages.
//  - Illegal NCLOCKS: elaboration fails via a generate-time error stub.
// CONFIGURATION
//  BIGSUB_SATURATE_EN
//   - Defined: a result with borrow=1 is clamped to o_r=0, and o_borrow is
//     still reported as 1. The clamp is applied in the final stage and adds
//     no latency.
//   - Undefined: o_r is the raw modulo-2^64 difference.
//   - Latency and o_sync timing are identical either way.
// TESTING
//  1. Basic, every NCLOCKS: a=0x10, b=0x3 with i_sync=1 ->
//     NCLOCKS cycles later o_sync=1, o_r=0xD, o_borrow=0.
//  2. Cross-chunk borrow, NCLOCKS=4: a=0x0001_0000_0000_0000,
//     b=0x0000_0000_0000_0001 -> o_r=0x0000_FFFF_FFFF_FFFF, o_borrow=0.
//  3. Wrap: a=0, b=1 -> o_r=0xFFFF_FFFF_FFFF_FFFF, o_borrow=1.
//     With BIGSUB_SATURATE_EN defined -> o_r=0, o_borrow=1.
//  4. Back-to-back, NCLOCKS=2: i_sync=1 for 3 cycles with (5,3), (3,5), (7,7)
//     -> o_sync=1 for 3 cycles, o_r = 2, 0xFFFF_FFFF_FFFF_FFFE, 0 and
//     o_borrow = 0, 1, 0.
//  5. Reset mid-flight, NCLOCKS=4: i_sync at cycle 0, then i_reset pulsed at
//     cycle 2 -> o_sync never asserts for that op, and o_r=0 immediately
//     on reset.
//  6. Random soak: 10k random a/b with random i_sync, against a reference
//     model delayed by NCLOCKS -> zero mismatches for NCLOCKS 1, 2 and 4,
//     with the macro both on and off.

Source files
------------

// File: rtl/bigsub.sv
// Pipelined 64-bit unsigned subtractor: o_r = i_a - i_b (mod 2^64), with the borrow
// rippling one chunk of 64/NCLOCKS bits per clock and a sync strobe travelling alongside.
// Optional feature macro: BIGSUB_SATURATE_EN (clamp negative results to zero).
module bigsub #(
    parameter int unsigned NCLOCKS = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sync,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [63:0] o_r,
    output logic        o_borrow,
    output logic        o_sync
);

    localparam int unsigned W = 64 / NCLOCKS;

    // Reject unsupported depths at elaboration time.
    if (!(NCLOCKS == 1 || NCLOCKS == 2 || NCLOCKS == 4)) begin : g_bad_nclocks
        $error("bigsub: NCLOCKS must be 1, 2 or 4");
    end

    // Per-stage state: operands still needed by later chunks, the partial result
    // (finished low chunks ride along), the borrow out of the latest chunk, and sync.
    logic [63:0] a_q   [NCLOCKS];
    logic [63:0] b_q   [NCLOCKS];
    logic [63:0] r_q   [NCLOCKS];
    logic        br_q  [NCLOCKS];
    logic        sync_q[NCLOCKS];

    logic [63:0] a_d   [NCLOCKS];
    logic [63:0] b_d   [NCLOCKS];
    logic [63:0] r_d   [NCLOCKS];
    logic        br_d  [NCLOCKS];
    logic        sync_d[NCLOCKS];

    logic [W:0]  diff0;
    logic [W:0]  diff_k;

    // Next-state: stage 0 does chunk 0, stage k does chunk k using the borrow from stage k-1.
    always_comb begin
        for (int k = 0; k < NCLOCKS; k++) begin
            a_d[k]    = '0;
            b_d[k]    = '0;
            r_d[k]    = '0;
            br_d[k]   = 1'b0;
            sync_d[k] = 1'b0;
        end
        diff_k = '0;

        diff0           = {1'b0, i_a[W-1:0]} - {1'b0, i_b[W-1:0]};
        a_d[0]          = i_a;
        b_d[0]          = i_b;
        r_d[0][W-1:0]   = diff0[W-1:0];
        br_d[0]         = diff0[W];
        sync_d[0]       = i_sync;

        for (int k = 1; k < NCLOCKS; k++) begin
            diff_k = {1'b0, a_q[k-1][k*W +: W]} - {1'b0, b_q[k-1][k*W +: W]}
                     - {{W{1'b0}}, br_q[k-1]};
            a_d[k]            = a_q[k-1];
            b_d[k]            = b_q[k-1];
            r_d[k]            = r_q[k-1];
            r_d[k][k*W +: W]  = diff_k[W-1:0];
            br_d[k]           = diff_k[W];
            sync_d[k]         = sync_q[k-1];
        end

`ifdef BIGSUB_SATURATE_EN
        // Clamp in front of the last register so latency is unchanged.
        if (br_d[NCLOCKS-1]) begin
            r_d[NCLOCKS-1] = '0;
        end
`endif
    end

    // Pipeline registers load every clock; reset clears data, borrow and sync.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NCLOCKS; k++) begin
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                r_q[k]    <= '0;
                br_q[k]   <= 1'b0;
                sync_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NCLOCKS; k++) begin
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
                r_q[k]    <= r_d[k];
                br_q[k]   <= br_d[k];
                sync_q[k] <= sync_d[k];
            end
        end
    end

    // Outputs come straight from the last stage.
    always_comb begin
        o_r      = r_q[NCLOCKS-1];
        o_borrow = br_q[NCLOCKS-1];
        o_sync   = sync_q[NCLOCKS-1];
    end

endmodule

// File: tb/tb_bigsub.sv
// Scoreboard bench for bigsub: stimulus pushes expected results, a negedge monitor
// pops and compares whenever o_sync is high (value, borrow and arrival cycle).
module tb_bigsub;

    localparam int unsigned NCLOCKS = 4;

    typedef struct {
        logic [63:0] r;
        logic        borrow;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        borrow;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_sync = 1'b0;
    logic [63:0] i_a = '0;
    logic [63:0] i_b = '0;
    logic [63:0] o_r;
    logic        o_borrow;
    logic        o_sync;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t vecs[$];

    bigsub #(.NCLOCKS(NCLOCKS)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_sync  (i_sync),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_r     (o_r),
        .o_borrow(o_borrow),
        .o_sync  (o_sync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Clamp applied to a raw expected difference when saturation is built in.
    function automatic logic [63:0] sat(input logic [63:0] r, input logic bw);
`ifdef BIGSUB_SATURATE_EN
        return bw ? 64'd0 : r;
`else
        return r;
`endif
    endfunction

    // Monitor: every o_sync outside reset must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && o_sync) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_o_sync: got o_sync=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("o_r", o_r, e.r);
                check("o_borrow", {63'd0, o_borrow}, {63'd0, e.borrow});
                check("latency", cyc, e.cyc);
            end
        end
    end

    // Present one operation this cycle and record what must emerge NCLOCKS later.
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] r, input logic bw);
        exp_t e;
        i_sync = 1'b1;
        i_a    = a;
        i_b    = b;
        e.r      = sat(r, bw);
        e.borrow = bw;
        e.cyc    = cyc + NCLOCKS;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_sync = 1'b0;
            i_a    = {$urandom, $urandom};
            i_b    = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget = 100;
        i_sync = 1'b0;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic add_vec(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] r, input logic bw);
        vec_t v;
        v.a = a;
        v.b = b;
        v.r = r;
        v.borrow = bw;
        vecs.push_back(v);
    endtask

    initial begin
        // Hand-computed vectors: raw difference and borrow.
        add_vec(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_000D, 1'b0);
        add_vec(64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h0000_FFFF_FFFF_FFFF, 1'b0);
        add_vec(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        add_vec(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 1'b0);
        add_vec(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0005, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        add_vec(64'h0000_0000_0000_0007, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0000, 1'b0);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        add_vec(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        add_vec(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0);
        add_vec(64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        add_vec(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h0246_8ACF_1357_9BCF, 1'b0);

        // Reset state, sampled while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_r", o_r, 64'd0);
        check("reset_o_borrow", {63'd0, o_borrow}, 64'd0);
        check("reset_o_sync", {63'd0, o_sync}, 64'd0);
        rst = 1'b0;
        idle(2);

        // Single isolated op, then the whole table back-to-back.
        issue(vecs[0].a, vecs[0].b, vecs[0].r, vecs[0].borrow);
        idle(NCLOCKS + 2);
        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].borrow);
        drain();
        idle(2);

        // Reset while an op is in flight: it must never appear, outputs clear at once.
        issue(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_00FF, 1'b0);
        idle(1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("midreset_o_r", o_r, 64'd0);
        check("midreset_o_sync", {63'd0, o_sync}, 64'd0);
        check("midreset_o_borrow", {63'd0, o_borrow}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(NCLOCKS + 3);

        // Short random run with sparse i_sync, checked against a plain 65-bit subtract.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                logic [63:0] a;
                logic [63:0] b;
                logic [64:0] d;
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                if (i % 7 == 0) b[63:32] = a[63:32];
                d = {1'b0, a} - {1'b0, b};
                issue(a, b, d[63:0], d[64]);
            end else begin
                idle(1);
            end
        end
        drain();
        idle(NCLOCKS + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
